// File: rtl/uart_tx_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo_if
// Description : Byte handshake between a producer and the buffered UART
//               transmitter (tx_data / tx_valid / tx_ready).
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_fifo_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : Buffered UART transmitter. Bytes enter a small FIFO over a
//               valid/ready handshake and leave LSB-first on tx as 8N1 frames,
//               every bit held CLOCK_HZ/BAUD_RATE clocks. Defining the macro
//               UART_TX_PARITY_EN adds an even-parity bit (8E1 framing).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int CLOCK_HZ   = 50_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic                          clk,
    input  wire logic                          rst_n,
    uart_tx_fifo_if.slave                      bus,
    output logic                               tx,
    output logic                               busy_flag,
    output logic [$clog2(FIFO_DEPTH):0]        fifo_count
);

    localparam int DIV   = CLOCK_HZ / BAUD_RATE;
    localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = AW + 1;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd4;
`endif

    // Reject configurations the datapath cannot support
    if (DIV < 2) begin : g_bad_div
        $error("uart_tx_fifo: CLOCK_HZ/BAUD_RATE must be at least 2");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
    end

    logic [7:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    logic [2:0]       state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;

    logic             full;
    logic             not_empty;
    logic             push;
    logic             pop;
    logic             baud_done;
    logic [7:0]       head;

    // Ready comes only from registered occupancy, so a same-cycle pop never
    // opens a slot for a push while full.
    assign full          = (count == CW'(FIFO_DEPTH));
    assign not_empty     = (count != '0);
    assign bus.tx_ready  = !full;
    assign push          = bus.tx_valid && !full;
    assign baud_done     = (baud_cnt == CNT_W'(DIV - 1));
    assign head          = mem[rd_ptr];
    assign fifo_count    = count;

    // A byte leaves the FIFO when the line is idle, or straight out of the
    // stop bit so consecutive frames have no idle gap.
    assign pop = not_empty && ((state == IDLE) || ((state == STOP) && baud_done));

    // FIFO storage; contents need no reset because count guards every read
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.tx_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Frame sequencer: start bit, 8 data bits LSB first, optional parity, stop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tx        <= 1'b1;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            busy_flag <= 1'b0;
        end else begin
            busy_flag <= (state != IDLE) || not_empty;
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    if (not_empty) begin
                        shreg <= head;
                        tx    <= 1'b0;
                        state <= START;
                    end else begin
                        tx <= 1'b1;
                    end
                end
                START: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        tx       <= shreg[0];
                        bit_idx  <= '0;
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            tx    <= ^shreg;
                            state <= PARITY;
`else
                            tx    <= 1'b1;
                            state <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shreg[bit_idx + 3'd1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        tx       <= 1'b1;
                        state    <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        if (not_empty) begin
                            shreg <= head;
                            tx    <= 1'b0;
                            state <= START;
                        end else begin
                            tx    <= 1'b1;
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    baud_cnt <= '0;
                    tx       <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_fifo
// Description : Randomised bench for uart_tx_fifo. A frame-level reference
//               model predicts tx, tx_ready, fifo_count and busy_flag every
//               cycle; a serial receiver decodes tx and checks bytes against
//               a scoreboard queue filled at push time.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

    localparam int CLOCK_HZ  = 1_843_200;
    localparam int BAUD_RATE = 115200;
    localparam int DEPTH     = 4;
    localparam int DIV       = CLOCK_HZ / BAUD_RATE;
`ifdef UART_TX_PARITY_EN
    localparam int NB        = 11;
`else
    localparam int NB        = 10;
`endif

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic                      tx;
    logic                      busy_flag;
    logic [$clog2(DEPTH):0]    fifo_count;

    uart_tx_fifo_if bus_if ();

    uart_tx_fifo #(
        .CLOCK_HZ   (CLOCK_HZ),
        .BAUD_RATE  (BAUD_RATE),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus_if),
        .tx         (tx),
        .busy_flag  (busy_flag),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: actual %0h required %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Line level of bit slot idx of a frame carrying byte b
    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
`ifdef UART_TX_PARITY_EN
        if (idx == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // Reference model state
    logic [7:0] model_q[$];
    logic [7:0] sb[$];
    longint     cyc = 0;
    longint     last_start = 0;
    longint     next_free = 0;
    bit         have_frame = 1'b0;
    logic [7:0] cur_byte = 8'h00;
    bit         m_push = 1'b0;
    bit         m_pop;
    int         cnt_before;
    logic       exp_tx = 1'b1;
    logic       exp_ready = 1'b1;
    logic       exp_busy = 1'b0;
    int         exp_count = 0;

    // Receiver state
    bit         dec_active = 1'b0;
    int         dec_cnt = 0;
    int         dec_idx;
    logic [7:0] dec_byte = 8'h00;
    logic [7:0] sb_head;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            m_push = 1'b0;
            if (rst_n) begin
                cnt_before = model_q.size();
                exp_busy   = (have_frame && (cyc - 1 < next_free)) || (cnt_before != 0);
                m_pop      = (cnt_before > 0) && (cyc >= next_free);
                m_push     = bus_if.tx_valid && (cnt_before < DEPTH);
                if (m_pop) begin
                    cur_byte   = model_q.pop_front();
                    last_start = cyc;
                    next_free  = cyc + NB * DIV;
                    have_frame = 1'b1;
                end
                if (m_push) begin
                    model_q.push_back(bus_if.tx_data);
                    sb.push_back(bus_if.tx_data);
                end
                exp_count = model_q.size();
                exp_ready = (exp_count < DEPTH);
                if (have_frame && cyc < next_free)
                    exp_tx = frame_bit(cur_byte, int'((cyc - last_start) / DIV));
                else
                    exp_tx = 1'b1;
            end

            @(negedge clk);
            if (!rst_n) begin
                model_q.delete();
                sb.delete();
                have_frame = 1'b0;
                next_free  = 0;
                exp_tx     = 1'b1;
                exp_ready  = 1'b1;
                exp_count  = 0;
                exp_busy   = 1'b0;
                dec_active = 1'b0;
            end
            check("tx", tx, exp_tx);
            check("tx_ready", bus_if.tx_ready, exp_ready);
            check("fifo_count", fifo_count, exp_count);
            check("busy_flag", busy_flag, exp_busy);

            // Serial receiver: sample each bit at mid-period
            if (rst_n) begin
                if (!dec_active) begin
                    if (tx === 1'b0) begin
                        dec_active = 1'b1;
                        dec_cnt    = 0;
                    end
                end else begin
                    dec_cnt++;
                end
                if (dec_active && (dec_cnt % DIV) == DIV / 2) begin
                    dec_idx = dec_cnt / DIV;
                    if (dec_idx == 0) begin
                        check("rx_start_bit", tx, 1'b0);
                    end else if (dec_idx <= 8) begin
                        dec_byte[dec_idx-1] = tx;
`ifdef UART_TX_PARITY_EN
                    end else if (dec_idx == 9) begin
                        check("rx_parity_bit", tx, ^dec_byte);
`endif
                    end else begin
                        check("rx_stop_bit", tx, 1'b1);
                        check("rx_frame_expected", sb.size() > 0, 1'b1);
                        if (sb.size() > 0) begin
                            sb_head = sb.pop_front();
                            check("rx_byte", dec_byte, sb_head);
                        end
                        dec_active = 1'b0;
                    end
                end
            end
        end
    end

    // Offer one byte and hold it until the FIFO takes it
    task automatic send(input logic [7:0] b, input int gap);
        int budget;
        bus_if.tx_valid = 1'b1;
        bus_if.tx_data  = b;
        budget = 0;
        do begin
            @(posedge clk);
            #2;
            budget++;
        end while (!m_push && budget < 20 * NB * DIV);
        check("push_accepted", m_push, 1'b1);
        bus_if.tx_valid = 1'b0;
        bus_if.tx_data  = 8'($urandom);
        repeat (gap) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Let every queued and in-flight frame drain, then confirm the scoreboard
    task automatic wait_idle();
        int budget;
        budget = 0;
        do begin
            @(posedge clk);
            #2;
            budget++;
        end while ((sb.size() != 0 || model_q.size() != 0 || cyc < next_free + 4)
                   && budget < 10 * NB * DIV * DEPTH);
        check("drained", sb.size(), 0);
    endtask

    initial begin
        bus_if.tx_valid = 1'b0;
        bus_if.tx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #2;
        end

        // Single frame
        send(8'hA5, 0);
        wait_idle();

        // Back-to-back frames
        send(8'h3C, 0);
        send(8'hC3, 0);
        wait_idle();

        // Burst that overfills the FIFO
        for (int i = 0; i < 6; i++) send(8'h10 + 8'(i), 0);
        wait_idle();

        // Reset in the middle of bit 3 with bytes queued
        send(8'h55, 0);
        send(8'h01, 0);
        send(8'h02, 0);
        repeat (4 * DIV + DIV / 2 - 1) @(posedge clk);
        #2 rst_n = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (3 * NB * DIV) @(posedge clk);
        #2;

        // Extreme patterns
        send(8'h00, 0);
        send(8'hFF, 0);
        send(8'h81, 0);
        wait_idle();

        // Parity pair
        send(8'hA5, 0);
        send(8'h01, 0);
        wait_idle();

        // Random traffic with mostly back-to-back offers
        for (int i = 0; i < 40; i++) begin
            send(8'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3 * NB * DIV)) : 0);
        end
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
